// File: rtl/uart_com.sv
// uart_com: 8N1 UART for the COM device; define UART_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register
module uart_com #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  input  logic [7:0] com_data_out,
  input  logic       enable_com_write,
  output logic       com_write_ready,
  output logic [7:0] com_data_in,
  output logic       com_read_ready,
  input  logic       int_com_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_err_q, rx_err_d, ack_q, ovr_q, ovr_d;
  logic tx_end, push, pop, do_push;
  assign txd = (tx_state_q == START) ? 1'b0 : (tx_state_q == DATA) ? tx_shift_q[0] : 1'b1;
  assign com_write_ready = tx_state_q == IDLE;
  assign rx_overrun = ovr_q;
  assign rx_frame_err = rx_err_q;
  assign pop = int_com_ack & ~ack_q;
  assign tx_end = tx_cnt_q == LAST;
  // TX sequencing: each of start, 8 data and stop bits lasts DIV cycles
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d = tx_end ? '0 : tx_cnt_q + ONE;
    tx_bit_d = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (enable_com_write) begin
          tx_state_d = START;
          tx_shift_d = com_data_out;
        end
      end
      START: tx_state_d = tx_end ? DATA : START;
      DATA: if (tx_end) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_state_d = (tx_bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: tx_state_d = tx_end ? IDLE : STOP;
    endcase
  end
  // RX sequencing: mid-bit sampling of the synchronised line, start glitch rejection
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d = rx_cnt_q + ONE;
    rx_bit_d = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_err_d = 1'b0;
    push = 1'b0;
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        rx_state_d = (rx_prev_q & ~rx_s2_q) ? START : IDLE;
      end
      START: if (rx_cnt_q == HALF) begin
        rx_cnt_d = '0;
        rx_state_d = rx_s2_q ? IDLE : DATA;
      end
      DATA: if (rx_cnt_q == LAST) begin
        rx_cnt_d = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_state_d = (rx_bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (rx_cnt_q == LAST) begin
        rx_state_d = IDLE;
        push = rx_s2_q;
        rx_err_d = ~rx_s2_q;
      end
    endcase
  end
  // Overrun is sticky until the next consume
  always_comb ovr_d = pop ? 1'b0 : ovr_q | (push & ~do_push);
  // TX/RX state, synchroniser and ack edge registers
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_shift_q <= '0;
      rx_state_q <= IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_shift_q <= '0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_err_q <= 1'b0;
      ack_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_err_q <= rx_err_d;
      ack_q <= int_com_ack;
      ovr_q <= ovr_d;
    end
  end
`ifdef UART_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;
  logic do_pop;
  assign com_read_ready = cnt_q != 3'd0;
  assign com_data_in = mem_q[rp_q];
  // Circular FIFO: a pop frees a slot for a push in the same cycle
  always_comb begin
    do_pop = pop & (cnt_q != 3'd0);
    do_push = push & ((cnt_q != 3'd4) | do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = rx_shift_q;
    wp_d = wp_q + {1'b0, do_push};
    rp_d = rp_q + {1'b0, do_pop};
    cnt_d = cnt_q + {2'b0, do_push} - {2'b0, do_pop};
  end
  // FIFO storage and pointers
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d;
  assign com_read_ready = valid_q;
  assign com_data_in = data_q;
  // Holding register: a simultaneous pop lets the new byte replace the old one
  always_comb begin
    do_push = push & (~valid_q | pop);
    data_d = do_push ? rx_shift_q : data_q;
    valid_d = do_push | (valid_q & ~pop);
  end
  // Holding register storage
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
`endif
endmodule

// File: tb/tb_uart_com.sv
// tb_uart_com: directed self-checking bench for uart_com at default baud settings
module tb_uart_com;
  localparam int DIV = 434;
  logic clk50M = 1'b0, rst = 1'b0, rxd = 1'b1, txd, enable_com_write = 1'b0, com_write_ready;
  logic com_read_ready, int_com_ack = 1'b0, rx_overrun, rx_frame_err;
  logic [7:0] com_data_out = 8'h00, com_data_in;
  int checks = 0, passed = 0, err_pulses = 0;

  uart_com dut (
    .clk50M(clk50M), .rst(rst), .rxd(rxd), .txd(txd),
    .com_data_out(com_data_out), .enable_com_write(enable_com_write),
    .com_write_ready(com_write_ready), .com_data_in(com_data_in),
    .com_read_ready(com_read_ready), .int_com_ack(int_com_ack),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  always #10 clk50M = ~clk50M;
  always @(negedge clk50M) if (rx_frame_err === 1'b1) err_pulses++;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit inject, input string tag);
    int bad;
    logic exp;
    @(negedge clk50M);
    com_data_out = b;
    enable_com_write = 1'b1;
    @(negedge clk50M);
    enable_com_write = 1'b0;
    com_data_out = 8'h00;
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int c = 0; c < DIV; c++) begin
        if (txd !== exp || com_write_ready !== 1'b0) bad++;
        enable_com_write = inject && k == 3 && c == 100;
        com_data_out = (inject && k == 3 && c == 100) ? 8'hFF : 8'h00;
        @(negedge clk50M);
      end
      checks++;
      if (bad !== 0) $display("FAIL %s bit%0d: %0d of %0d cycles wrong, required txd=%b ready=0", tag, k, bad, DIV, exp);
      else passed++;
    end
    checks++;
    if ({txd, com_write_ready} !== 2'b11) $display("FAIL %s end: txd,ready=%b%b required 11", tag, txd, com_write_ready);
    else passed++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cycles(DIV);
    end
    rxd = stop;
    cycles(DIV);
    rxd = 1'b1;
  endtask

  task automatic ack;
    @(negedge clk50M);
    int_com_ack = 1'b1;
    cycles(3);
    int_com_ack = 1'b0;
    cycles(2);
  endtask

  task automatic test_reset;
    #25;
    checks++;
    if ({txd, com_write_ready, com_read_ready, com_data_in, rx_overrun, rx_frame_err} !== {3'b110, 8'h00, 2'b00})
      $display("FAIL reset: txd=%b wr=%b rr=%b data=%h ovr=%b ferr=%b required 1 1 0 00 0 0",
               txd, com_write_ready, com_read_ready, com_data_in, rx_overrun, rx_frame_err);
    else passed++;
    @(negedge clk50M);
    rst = 1'b1;
    cycles(3);
    checks++;
    if ({txd, com_write_ready, com_read_ready} !== 3'b110)
      $display("FAIL post_reset: txd,wr,rr=%b%b%b required 110", txd, com_write_ready, com_read_ready);
    else passed++;
  endtask

  task automatic test_tx;
    tx_frame(8'h55, 1'b0, "tx_55");
  endtask

  task automatic test_ignore_busy;
    tx_frame(8'h55, 1'b1, "tx_busy");
  endtask

  task automatic test_rx;
    int e0;
    e0 = err_pulses;
    checks++;
    if (com_read_ready !== 1'b0) $display("FAIL rx_idle: ready=%b required 0", com_read_ready);
    else passed++;
    send_byte(8'hA5, 1'b1);
    cycles(2);
    checks++;
    if (com_read_ready !== 1'b1) $display("FAIL rx_ready: ready=%b required 1", com_read_ready);
    else passed++;
    checks++;
    if (com_data_in !== 8'hA5) $display("FAIL rx_data: data=%h required a5", com_data_in);
    else passed++;
    ack();
    checks++;
    if (com_read_ready !== 1'b0) $display("FAIL rx_ack: ready=%b required 0", com_read_ready);
    else passed++;
    checks++;
    if (err_pulses !== e0) $display("FAIL rx_noerr: pulses=%0d required %0d", err_pulses, e0);
    else passed++;
  endtask

  task automatic test_glitch;
    int e0;
    e0 = err_pulses;
    @(negedge clk50M);
    rxd = 1'b0;
    cycles(100);
    rxd = 1'b1;
    cycles(2 * DIV);
    checks++;
    if (com_read_ready !== 1'b0) $display("FAIL glitch_ready: ready=%b required 0", com_read_ready);
    else passed++;
    checks++;
    if (err_pulses !== e0) $display("FAIL glitch_err: pulses=%0d required %0d", err_pulses, e0);
    else passed++;
  endtask

  task automatic test_frame_err;
    int e0;
    e0 = err_pulses;
    send_byte(8'h3C, 1'b0);
    cycles(10);
    checks++;
    if (err_pulses !== e0 + 1) $display("FAIL frame_err: pulse cycles=%0d required %0d", err_pulses - e0, 1);
    else passed++;
    checks++;
    if (com_read_ready !== 1'b0) $display("FAIL frame_err_ready: ready=%b required 0", com_read_ready);
    else passed++;
  endtask

  task automatic test_overrun;
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    cycles(5);
    checks++;
    if ({com_read_ready, rx_overrun} !== 2'b10) $display("FAIL fifo_full: ready,ovr=%b%b required 10", com_read_ready, rx_overrun);
    else passed++;
    send_byte(8'h05, 1'b1);
    cycles(5);
    checks++;
    if (rx_overrun !== 1'b1) $display("FAIL fifo_ovr: ovr=%b required 1", rx_overrun);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (com_data_in !== 8'(i)) $display("FAIL fifo_head%0d: data=%h required %h", i, com_data_in, 8'(i));
      else passed++;
      ack();
      if (i == 1) begin
        checks++;
        if (rx_overrun !== 1'b0) $display("FAIL fifo_ovr_clr: ovr=%b required 0", rx_overrun);
        else passed++;
      end
    end
    checks++;
    if (com_read_ready !== 1'b0) $display("FAIL fifo_empty: ready=%b required 0", com_read_ready);
    else passed++;
`else
    send_byte(8'h01, 1'b1);
    cycles(5);
    checks++;
    if ({com_read_ready, rx_overrun} !== 2'b10) $display("FAIL ovr_first: ready,ovr=%b%b required 10", com_read_ready, rx_overrun);
    else passed++;
    send_byte(8'h02, 1'b1);
    cycles(5);
    checks++;
    if (rx_overrun !== 1'b1) $display("FAIL ovr_set: ovr=%b required 1", rx_overrun);
    else passed++;
    checks++;
    if (com_data_in !== 8'h01) $display("FAIL ovr_keep: data=%h required 01", com_data_in);
    else passed++;
    ack();
    checks++;
    if (rx_overrun !== 1'b0) $display("FAIL ovr_clr: ovr=%b required 0", rx_overrun);
    else passed++;
    checks++;
    if (com_read_ready !== 1'b0) $display("FAIL ovr_empty: ready=%b required 0", com_read_ready);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_tx;
    @(negedge clk50M);
    com_data_out = 8'hC3;
    enable_com_write = 1'b1;
    @(negedge clk50M);
    enable_com_write = 1'b0;
    com_data_out = 8'h00;
    cycles(4 * DIV + 200);
    checks++;
    if ({txd, com_write_ready} !== 2'b00) $display("FAIL mid_tx_bit3: txd,ready=%b%b required 00", txd, com_write_ready);
    else passed++;
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({txd, com_write_ready} !== 2'b11) $display("FAIL async_reset: txd,ready=%b%b required 11", txd, com_write_ready);
    else passed++;
    @(negedge clk50M);
    rst = 1'b1;
    cycles(2);
    tx_frame(8'h81, 1'b0, "tx_81");
  endtask

  initial begin
    test_reset();
    test_tx();
    test_ignore_busy();
    test_rx();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uart_com.md
# uart_com

Serial port controller for the CPU's COM device. Converts the byte-wide write strobe and read handshake used by the physical memory controller into asynchronous 8N1 serial frames on `txd` and `rxd`, and converts received frames back into bytes. Sits directly downstream of the memory controller's COM data/status decode and drives that controller's `com_data_in`, `com_read_ready` and `com_write_ready` inputs.

## Interface
- `CLK_FREQ`, default 50000000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. Bit period `DIV = CLK_FREQ/BAUD`, truncated to an integer (434 at the defaults). Counters are wide enough for DIV; DIV ≥ 16 is required.

Ports:
- `clk50M`  in  1  system clock; all logic is on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial input, asynchronous to `clk50M`, idle high.
- `txd`  out  1  serial output, idle high.
- `com_data_out`  in  8  byte to transmit; sampled with `enable_com_write`.
- `enable_com_write`  in  1  one-cycle transmit request.
- `com_write_ready`  out  1  transmitter idle; a request will be accepted.
- `com_data_in`  out  8  received byte (head of buffer).
- `com_read_ready`  out  1  received byte available.
- `int_com_ack`  in  1  level, high while the CPU reads the data register; a rising edge consumes one byte.
- `rx_overrun`  out  1  sticky flag: a byte was lost because the buffer was full.
- `rx_frame_err`  out  1  one-cycle pulse when the stop bit samples low.

## Operation
- Reset values: `txd`=1, `com_write_ready`=1, `com_read_ready`=0, `com_data_in`=0, `rx_overrun`=0, `rx_frame_err`=0. Both FSMs return to IDLE. Reset mid-frame aborts the frame; `txd` goes high asynchronously.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - In IDLE, `enable_com_write`=1 latches `com_data_out` and moves to START.
  - `txd` shows start 0, then data bits LSB first, then stop 1. Each bit is held for DIV cycles.
  - `com_write_ready` is 1 only in IDLE.
  - A request that arrives while not in IDLE is ignored, with no side effects.
- RX input is synchronised by a 2-flop chain; all RX logic uses the synchronised signal.
- RX FSM: IDLE → START → DATA → STOP → IDLE.
  - A 1→0 transition in IDLE enters START.
  - At DIV/2 cycles, the line is resampled. If it is 1, the event is a glitch and the FSM returns to IDLE. If it is 0, the FSM enters DATA.
  - Eight samples are taken DIV cycles apart, shifted in LSB first.
  - The stop bit is sampled DIV cycles after bit 7.
  - Stop=1: the byte is pushed to the buffer. Stop=0: `rx_frame_err` pulses and the byte is discarded.
  - In both cases the FSM returns to IDLE on the same cycle and can detect the next start edge immediately.
- Consume: a rising edge of `int_com_ack` (registered previous value) pops the buffer head. A pop when empty has no effect.
- Overrun: a push when the buffer is full drops the new byte and sets `rx_overrun`. The next consume clears `rx_overrun`.
- Simultaneous push and pop in the same cycle:
  - Single-register mode: the new byte replaces the old one and `com_read_ready` stays 1.
  - FIFO mode: the pop and push both take effect and the count is unchanged.

## Timing
- TX: `txd` falls on the cycle after `enable_com_write` is sampled. The frame lasts 10×DIV cycles. `com_write_ready` rises on the cycle after the stop bit's last cycle.
- RX: `com_read_ready` and `com_data_in` update on the cycle after the stop-bit sample. That is about 9.5×DIV cycles plus 2 synchroniser cycles after the start edge.
- `com_read_ready` falls on the cycle after the `int_com_ack` rising edge is registered, unless more bytes remain.
- `com_data_in` is registered and stable whenever `com_read_ready`=1.

## Configuration
- `UART_RX_FIFO_EN` defined: the RX buffer is a 4-entry circular FIFO.
  - 2-bit pointers wrap 3→0, and a 3-bit count is kept.
  - `com_read_ready` = (count≠0).
  - `com_data_in` shows the head entry.
  - Full means count=4; overrun happens on the 5th unconsumed byte.
- `UART_RX_FIFO_EN` undefined: the buffer is a single holding register.
  - Full means `com_read_ready`=1; overrun happens on the 2nd unconsumed byte.

## Test plan
- Defaults, pulse `enable_com_write` with 0x55 → `txd` low for 434 cycles, then 1,0,1,0,1,0,1,0 each 434 cycles, then high. `com_write_ready` returns to 1 at cycle 4341.
- Second `enable_com_write` (0xFF) during the 0x55 frame → ignored; the 0x55 waveform is unchanged.
- Drive an rxd frame of 0xA5 → `com_read_ready`=1 with `com_data_in`=0xA5. An `int_com_ack` pulse → `com_read_ready`=0.
- rxd low for 100 cycles only → no byte and no error. Frame 0x3C with stop=0 → one `rx_frame_err` pulse, `com_read_ready` stays 0.
- Frames 0x01, 0x02 without ack:
  - Single-register mode → `rx_overrun`=1, `com_data_in`=0x01.
  - FIFO mode → five frames give `rx_overrun`=1, and acks return 0x01..0x04.
  - In both modes, the first ack clears `rx_overrun`.
- Assert `rst`=0 mid-TX at bit 3 → `txd`=1 and `com_write_ready`=1 immediately. After release, a 0x81 transmit has a correct waveform.
